// File: rtl/ram4k16_arbiter_pkg.sv
// Shared definitions for the two-requester 4k x 16 SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram4k16_arbiter_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int BE_W     = 2;
    // Byte-enable bit positions: upper byte D[15:8], lower byte D[7:0].
    localparam int BE_UPPER = 1;
    localparam int BE_LOWER = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Expand byte enables into a 16-bit data mask; unselected bytes become zero.
    function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
        return {{8{be[BE_UPPER]}}, {8{be[BE_LOWER]}}};
    endfunction

endpackage

// File: rtl/ram4k16_arbiter.sv
// Two-requester arbiter in front of a 4k x 16 SRAM with byte strobes.
// Latency: REQ seen in IDLE -> ACK two edges later; one access every 3 cycles.
// Backpressure: level REQ held until ACK; a losing requester simply waits in IDLE.
module ram4k16_arbiter
    import ram4k16_arbiter_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_RST_n,
    input  logic              i_M0_REQ,
    input  logic              i_M0_WE,
    input  logic [ADDR_W-1:0] i_M0_ADDR,
    input  logic [BE_W-1:0]   i_M0_BE,
    input  logic [DATA_W-1:0] i_M0_WDATA,
    output logic              o_M0_ACK,
    output logic [DATA_W-1:0] o_M0_RDATA,
    input  logic              i_M1_REQ,
    input  logic              i_M1_WE,
    input  logic [ADDR_W-1:0] i_M1_ADDR,
    input  logic [BE_W-1:0]   i_M1_BE,
    input  logic [DATA_W-1:0] i_M1_WDATA,
    output logic              o_M1_ACK,
    output logic [DATA_W-1:0] o_M1_RDATA,
    output logic [ADDR_W-1:0] o_RAM_ADDR,
    output logic [DATA_W-1:0] o_RAM_DIN,
    output logic              o_RAM_RD_n,
    output logic              o_RAM_WR_n,
    output logic              o_RAM_SEL0_n,
    output logic              o_RAM_SEL1_n,
    input  logic [DATA_W-1:0] i_RAM_DOUT,
    output logic              o_BUSY
);

    state_t              state_q, state_d;
    logic                any_req;
    logic                gnt_sel;     // requester chosen this cycle
    logic                gnt_q;       // requester owning the current access
    logic                last_q;      // most recently granted requester
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic                sel_we;
    logic [BE_W-1:0]     sel_be;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    // Grant selection: single requester always wins; ties go by policy.
    always_comb begin
        any_req = i_M0_REQ | i_M1_REQ;
        gnt_sel = 1'b0;
        if (i_M0_REQ && i_M1_REQ) begin
            gnt_sel = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
        end else if (i_M1_REQ) begin
            gnt_sel = 1'b1;
        end
        sel_we = gnt_sel ? i_M1_WE : i_M0_WE;
        sel_be = gnt_sel ? i_M1_BE : i_M0_BE;
    end

    // Next-state: IDLE waits for a request, then ISSUE and DONE one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Capture the granted request and raise the SRAM strobes for exactly the ISSUE cycle.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            gnt_q        <= 1'b0;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            be_q         <= '0;
            o_RAM_ADDR   <= '0;
            o_RAM_DIN    <= '0;
            o_RAM_RD_n   <= 1'b1;
            o_RAM_WR_n   <= 1'b1;
            o_RAM_SEL0_n <= 1'b1;
            o_RAM_SEL1_n <= 1'b1;
        end else if (state_q == ST_IDLE && any_req) begin
            gnt_q        <= gnt_sel;
            last_q       <= gnt_sel;
            we_q         <= sel_we;
            be_q         <= sel_be;
            o_RAM_ADDR   <= gnt_sel ? i_M1_ADDR  : i_M0_ADDR;
            o_RAM_DIN    <= gnt_sel ? i_M1_WDATA : i_M0_WDATA;
            // With no byte selected the access is a no-op on the bus: keep all strobes high.
            o_RAM_RD_n   <= ~(~sel_we & (|sel_be));
            o_RAM_WR_n   <= ~( sel_we & (|sel_be));
            o_RAM_SEL0_n <= ~sel_be[BE_UPPER];
            o_RAM_SEL1_n <= ~sel_be[BE_LOWER];
        end else if (state_q == ST_ISSUE) begin
            o_RAM_RD_n   <= 1'b1;
            o_RAM_WR_n   <= 1'b1;
            o_RAM_SEL0_n <= 1'b1;
            o_RAM_SEL1_n <= 1'b1;
        end
    end

    // Latch read data at the edge ending ISSUE; an empty byte enable leaves it untouched.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == ST_ISSUE && !we_q && (|be_q)) begin
            if (gnt_q) rdata1_q <= i_RAM_DOUT & be_mask(be_q);
            else       rdata0_q <= i_RAM_DOUT & be_mask(be_q);
        end
    end

    assign o_M0_ACK   = (state_q == ST_DONE) && !gnt_q;
    assign o_M1_ACK   = (state_q == ST_DONE) &&  gnt_q;
    assign o_M0_RDATA = rdata0_q;
    assign o_M1_RDATA = rdata1_q;
    assign o_BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram4k16_arbiter.sv
// Bench for ram4k16_arbiter: round-robin (a) and fixed-priority (b) instances share requester stimulus.
// Latency: checks ACK two edges after REQ is driven.
// Backpressure: requesters hold REQ until ACK, then drop it.
module tb_ram4k16_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [1:0]  be0, be1;
    logic [15:0] wd0, wd1;

    logic        ack0_a, ack1_a, rd_n_a, wr_n_a, sel0_n_a, sel1_n_a, busy_a;
    logic [15:0] rdata0_a, rdata1_a, din_a, dout_a;
    logic [11:0] raddr_a;
    logic        ack0_b, ack1_b, rd_n_b, wr_n_b, sel0_n_b, sel1_n_b, busy_b;
    logic [15:0] rdata0_b, rdata1_b, din_b, dout_b;
    logic [11:0] raddr_b;

    logic [15:0] mem_a [4096];
    logic [15:0] mem_b [4096];
    int          strobe_cnt_a;
    int          both_low_cnt;

    int total = 0;
    int bad   = 0;

    ram4k16_arbiter #(.FIXED_PRI(0)) dut_a (
        .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n),
        .i_M0_REQ(req0), .i_M0_WE(we0), .i_M0_ADDR(addr0), .i_M0_BE(be0), .i_M0_WDATA(wd0),
        .o_M0_ACK(ack0_a), .o_M0_RDATA(rdata0_a),
        .i_M1_REQ(req1), .i_M1_WE(we1), .i_M1_ADDR(addr1), .i_M1_BE(be1), .i_M1_WDATA(wd1),
        .o_M1_ACK(ack1_a), .o_M1_RDATA(rdata1_a),
        .o_RAM_ADDR(raddr_a), .o_RAM_DIN(din_a), .o_RAM_RD_n(rd_n_a), .o_RAM_WR_n(wr_n_a),
        .o_RAM_SEL0_n(sel0_n_a), .o_RAM_SEL1_n(sel1_n_a), .i_RAM_DOUT(dout_a), .o_BUSY(busy_a)
    );

    ram4k16_arbiter #(.FIXED_PRI(1)) dut_b (
        .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n),
        .i_M0_REQ(req0), .i_M0_WE(we0), .i_M0_ADDR(addr0), .i_M0_BE(be0), .i_M0_WDATA(wd0),
        .o_M0_ACK(ack0_b), .o_M0_RDATA(rdata0_b),
        .i_M1_REQ(req1), .i_M1_WE(we1), .i_M1_ADDR(addr1), .i_M1_BE(be1), .i_M1_WDATA(wd1),
        .o_M1_ACK(ack1_b), .o_M1_RDATA(rdata1_b),
        .o_RAM_ADDR(raddr_b), .o_RAM_DIN(din_b), .o_RAM_RD_n(rd_n_b), .o_RAM_WR_n(wr_n_b),
        .o_RAM_SEL0_n(sel0_n_b), .o_RAM_SEL1_n(sel1_n_b), .i_RAM_DOUT(dout_b), .o_BUSY(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM elements: strobes and data sampled on the falling edge, read data registered there.
    always @(negedge clk) begin
        if (!rd_n_a && (!sel0_n_a || !sel1_n_a)) dout_a <= mem_a[raddr_a];
        if (!wr_n_a) begin
            if (!sel0_n_a) mem_a[raddr_a][15:8] <= din_a[15:8];
            if (!sel1_n_a) mem_a[raddr_a][7:0]  <= din_a[7:0];
        end
        if (!rd_n_b && (!sel0_n_b || !sel1_n_b)) dout_b <= mem_b[raddr_b];
        if (!wr_n_b) begin
            if (!sel0_n_b) mem_b[raddr_b][15:8] <= din_b[15:8];
            if (!sel1_n_b) mem_b[raddr_b][7:0]  <= din_b[7:0];
        end
        if (!rd_n_a || !wr_n_a || !sel0_n_a || !sel1_n_a) strobe_cnt_a <= strobe_cnt_a + 1;
        if ((!rd_n_a && !wr_n_a) || (!rd_n_b && !wr_n_b)) both_low_cnt <= both_low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [11:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_strobe;
    } vec_t;

    vec_t vecs[12];

    // One access by requester m; both instances see it alone, so both must behave identically.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int s0;
        logic ack_a, ack_b, oth_a;
        logic [15:0] rd_a, rd_b;
        s0 = strobe_cnt_a;
        if (v.m == 0) begin
            we0 = v.we; addr0 = v.addr; be0 = v.be; wd0 = v.wd; req0 = 1'b1;
        end else begin
            we1 = v.we; addr1 = v.addr; be1 = v.be; wd1 = v.wd; req1 = 1'b1;
        end
        lat = 0;
        ack_a = 1'b0;
        while (!ack_a && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            ack_a = (v.m == 0) ? ack0_a : ack1_a;
        end
        ack_b = (v.m == 0) ? ack0_b : ack1_b;
        oth_a = (v.m == 0) ? ack1_a : ack0_a;
        rd_a  = (v.m == 0) ? rdata0_a : rdata1_a;
        rd_b  = (v.m == 0) ? rdata0_b : rdata1_b;
        check($sformatf("v%0d ack_latency", idx), lat, 2);
        check($sformatf("v%0d ack_b", idx), {31'd0, ack_b}, 1);
        check($sformatf("v%0d other_ack", idx), {31'd0, oth_a}, 0);
        if (v.chk_rd) begin
            check($sformatf("v%0d rdata_a", idx), {16'd0, rd_a}, {16'd0, v.exp_rd});
            check($sformatf("v%0d rdata_b", idx), {16'd0, rd_b}, {16'd0, v.exp_rd});
        end
        check($sformatf("v%0d strobe_seen", idx), {31'd0, strobe_cnt_a != s0}, {31'd0, v.exp_strobe});
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d busy_after", idx), {31'd0, busy_a}, 0);
    endtask

    int na, nb, cyc, m1_seen;
    int seq_a[6];
    int seq_b[6];
    int overlap;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0, 1'b1, 12'h123, 2'b11, 16'hA55A, 1'b0, 16'h0000, 1'b1};
        vecs[1]  = '{0, 1'b0, 12'h123, 2'b11, 16'h0000, 1'b1, 16'hA55A, 1'b1};
        vecs[2]  = '{1, 1'b1, 12'h010, 2'b11, 16'h1234, 1'b0, 16'h0000, 1'b1};
        vecs[3]  = '{1, 1'b1, 12'h010, 2'b10, 16'hFF00, 1'b0, 16'h0000, 1'b1};
        vecs[4]  = '{1, 1'b0, 12'h010, 2'b11, 16'h0000, 1'b1, 16'hFF34, 1'b1};
        vecs[5]  = '{1, 1'b0, 12'h010, 2'b01, 16'h0000, 1'b1, 16'h0034, 1'b1};
        vecs[6]  = '{0, 1'b1, 12'hFFF, 2'b11, 16'hBEEF, 1'b0, 16'h0000, 1'b1};
        vecs[7]  = '{0, 1'b0, 12'hFFF, 2'b11, 16'h0000, 1'b1, 16'hBEEF, 1'b1};
        vecs[8]  = '{1, 1'b0, 12'hFFF, 2'b10, 16'h0000, 1'b1, 16'hBE00, 1'b1};
        vecs[9]  = '{0, 1'b1, 12'h123, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[10] = '{0, 1'b0, 12'h123, 2'b00, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        vecs[11] = '{0, 1'b0, 12'h123, 2'b11, 16'h0000, 1'b1, 16'hA55A, 1'b1};

        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        strobe_cnt_a = 0;
        both_low_cnt = 0;
        dout_a = 16'h0; dout_b = 16'h0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wd1 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy_a}, 0);
        check("reset acks", {30'd0, ack0_a, ack1_a}, 0);
        check("reset strobes", {28'd0, rd_n_a, wr_n_a, sel0_n_a, sel1_n_a}, 32'hF);
        check("reset ram_addr/din", {4'd0, raddr_a, din_a}, 0);
        check("reset rdata", {rdata0_a, rdata1_a}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
        check("addr held outside issue", {20'd0, raddr_a}, 32'h123);

        // Reset in the middle of a write's ISSUE cycle, before the SRAM samples it.
        we0 = 1'b1; addr0 = 12'h200; be0 = 2'b11; wd0 = 16'h1111; req0 = 1'b1;
        @(posedge clk); #1;
        check("issue wr_n low", {31'd0, wr_n_a}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset strobes a", {28'd0, rd_n_a, wr_n_a, sel0_n_a, sel1_n_a}, 32'hF);
        check("midreset strobes b", {28'd0, rd_n_b, wr_n_b, sel0_n_b, sel1_n_b}, 32'hF);
        check("midreset busy", {30'd0, busy_a, busy_b}, 0);
        check("midreset ram_addr", {20'd0, raddr_a}, 0);
        req0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        overlap = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack0_a || ack1_a || ack0_b || ack1_b) overlap++;
        end
        check("no ack after reset", overlap, 0);
        check("aborted write not stored", {16'd0, mem_a[12'h200]}, 0);

        // Contention: both requesters hold reads continuously.
        we0 = 1'b0; addr0 = 12'h123; be0 = 2'b11;
        we1 = 1'b0; addr1 = 12'h010; be1 = 2'b11;
        req0 = 1'b1; req1 = 1'b1;
        na = 0; nb = 0; overlap = 0; m1_seen = 0;
        for (cyc = 0; cyc < 60 && (na < 6 || nb < 6); cyc++) begin
            @(posedge clk); #1;
            if (ack0_a && ack1_a) overlap++;
            if ((ack0_a || ack1_a) && na < 6) begin seq_a[na] = ack1_a ? 1 : 0; na++; end
            if ((ack0_b || ack1_b) && nb < 6) begin seq_b[nb] = ack1_b ? 1 : 0; nb++; end
            if (ack1_b) m1_seen++;
        end
        check("contention acks a", na, 6);
        check("contention acks b", nb, 6);
        check("contention overlap", overlap, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr grant %0d", i), seq_a[i], i % 2);
            check($sformatf("fixed grant %0d", i), seq_b[i], 0);
        end
        check("fixed m1 starved", m1_seen, 0);
        check("contention rdata0", {16'd0, rdata0_a}, 32'hA55A);
        check("contention rdata1", {16'd0, rdata1_a}, 32'hFF34);

        // M0 releases: the fixed-priority instance must now serve M1.
        req0 = 1'b0;
        m1_seen = 0;
        for (cyc = 0; cyc < 10 && m1_seen == 0; cyc++) begin
            @(posedge clk); #1;
            if (ack1_b) m1_seen = 1;
        end
        check("fixed m1 after m0 drop", m1_seen, 1);
        check("fixed m1 rdata", {16'd0, rdata1_b}, 32'hFF34);
        req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rd_n/wr_n never both low", both_low_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram4k16_arbiter.md
RAM4K16_ARBITER -- requirements
Module: ram4k16_arbiter

Interface
REQ-001 Parameter: FIXED_PRI, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 i_EMU_MCLK  in  1  single system clock; all block state on its rising edge.
REQ-003 i_EMU_RST_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_Mn_REQ  in  1  per requester n in {0,1}: access request, level.
REQ-005 i_Mn_WE  in  1  per requester: 1 = write, 0 = read.
REQ-006 i_Mn_ADDR  in  12  per requester: word address.
REQ-007 i_Mn_BE  in  2  per requester, active-high byte enables: [1] = upper byte D[15:8], [0] = lower byte D[7:0].
REQ-008 i_Mn_WDATA  in  16  per requester: write data.
REQ-009 o_Mn_ACK  out  1  per requester: one-cycle completion pulse.
REQ-010 o_Mn_RDATA  out  16  per requester: read data, valid while o_Mn_ACK = 1 and held until that requester's next ACK.
REQ-011 o_RAM_ADDR / o_RAM_DIN  out  12 / 16  SRAM address and write data.
REQ-012 o_RAM_RD_n / o_RAM_WR_n / o_RAM_SEL0_n / o_RAM_SEL1_n  out  1 each  active-low SRAM strobes; SEL0 = upper byte, SEL1 = lower byte.
REQ-013 i_RAM_DOUT  in  16  SRAM read data; the SRAM registers it on the falling clock edge.
REQ-014 o_BUSY  out  1  high in every state other than IDLE.

Function
REQ-015 FSM states: IDLE, ISSUE, DONE. Transitions: IDLE->ISSUE on a grant; ISSUE->DONE always; DONE->IDLE always.
REQ-016 IDLE, any REQ high:
- Grant one requester.
- Register its ADDR, WDATA, WE and BE into the SRAM output registers.
- Record the grant index.
REQ-017 Arbitration when both REQ are high:
- FIXED_PRI=0: grant the requester not granted most recently.
- FIXED_PRI=1: grant requester 0.
- A single REQ is granted regardless of FIXED_PRI.
REQ-018 ISSUE: strobes driven so the SRAM samples them at the mid-cycle falling edge.
- RD_n = WE.
- WR_n = ~WE.
- SEL0_n = ~BE[1].
- SEL1_n = ~BE[0].
REQ-019 DONE:
- All strobes high.
- o_Mg_ACK = 1 for the granted requester g only.
- For a read, o_Mg_RDATA = i_RAM_DOUT sampled at the rising edge ending ISSUE, with unselected bytes forced to 8'h00.
REQ-020 Throughput and latency: one access per 3 cycles; REQ seen in IDLE at edge k gives ACK high during cycle k+2.
REQ-021 Handshake: the requester holds REQ and all request fields stable until it samples ACK, then drops or renews REQ. REQ seen high in IDLE after an ACK is a new access.
REQ-022 BE = 2'b00: ISSUE and DONE still occur and ACK pulses, but all strobes stay high and RDATA is unchanged.
REQ-023 RD_n and WR_n are never both low, and strobes are all high outside ISSUE.
REQ-024 REQ dropped during ISSUE or DONE (protocol violation): the access still completes and ACKs.
REQ-025 Address 12'hFFF is valid; there is no address wrap logic.
REQ-026 o_RAM_ADDR and o_RAM_DIN hold their last value outside ISSUE.

Reset
REQ-027 On i_EMU_RST_n low, immediately and including mid-access:
- State = IDLE.
- All strobes high.
- ACKs 0, RDATA 16'h0000, o_RAM_ADDR 0, o_RAM_DIN 0, o_BUSY 0.
- Last-grant = 1, so requester 0 wins the first tie.
REQ-028 An access interrupted by reset is never ACKed; the requester re-requests.

Structure
REQ-029 Shared package holds the FSM state encoding, address width 12, data width 16 and the byte-enable bit positions.
REQ-030 Single module with no sub-module; the two-way round-robin grant is inline logic. The bench instantiates the 4k x 16 SRAM element behind the RAM port.

Verification
REQ-031 Write/read: M0 writes 16'hA55A to 12'h123 with BE=11, then reads 12'h123 -> RDATA 16'hA55A, ACK 2 cycles after each REQ.
REQ-032 Byte lane:
- M1 writes 16'h1234 to 12'h010 with BE=11.
- M1 then writes 16'hFF00 with BE=10.
- Read with BE=11 -> 16'hFF34.
- Read with BE=01 -> 16'h0034.
REQ-033 Contention, FIXED_PRI=0, both REQ held for 6 accesses -> grant order M0,M1,M0,M1,M0,M1 and no ACK overlap.
REQ-034 Contention, FIXED_PRI=1, both held -> M0 takes every grant and M1 never ACKs until M0 drops REQ.
REQ-035 Boundaries:
- Write 16'hBEEF to 12'hFFF and read back -> 16'hBEEF.
- BE=00 access -> ACK with no strobe low.
REQ-036 Reset asserted during ISSUE of a write -> strobes high immediately, no ACK, o_BUSY 0; after release an M0/M1 tie grants M0.
